// File: rtl/button_capture.sv
// Push-button capture for the memory-game CPU read path: 2-FF synchronise, debounce,
// and hold one press event until the CPU acknowledges it and all buttons are released.
module button_capture #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             rd_ack,
  output logic [7:0]       data_out,
  output logic             valid
);

  typedef enum logic [1:0] {READY = 2'd0, PENDING = 2'd1, RELEASE = 2'd2} state_t;

  logic [N_BTN-1:0] s1, s2, deb, deb_next, rise;
  logic [CNT_W-1:0] cnt      [N_BTN];
  logic [CNT_W-1:0] cnt_next [N_BTN];
  state_t           state, state_next;
  logic             overrun, overrun_next, valid_next;
  logic [1:0]       idx, idx_next;

  function automatic logic [1:0] lowest_idx(input logic [N_BTN-1:0] r);
    logic [1:0] k;
    k = 2'b00;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (r[i]) k = 2'(i);
    end
    return k;
  endfunction

  // Two-flop synchroniser per button
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= {N_BTN{1'b0}};
      s2 <= {N_BTN{1'b0}};
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // Debounce: level changes only after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_next = deb;
    rise     = {N_BTN{1'b0}};
    for (int i = 0; i < N_BTN; i++) begin
      cnt_next[i] = cnt[i];
      if (s2[i] == deb[i]) begin
        cnt_next[i] = {CNT_W{1'b0}};
      end else if (cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
        deb_next[i] = s2[i];
        cnt_next[i] = {CNT_W{1'b0}};
        rise[i]     = s2[i];
      end else begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced levels and stability counters
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= {N_BTN{1'b0}};
      for (int i = 0; i < N_BTN; i++) cnt[i] <= {CNT_W{1'b0}};
    end else begin
      deb <= deb_next;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Event FSM; the ack decision looks at deb_next so a button rising on the ack
  // cycle still forces a release before it can produce a new event
  always_comb begin
    state_next   = state;
    valid_next   = valid;
    overrun_next = overrun;
    idx_next     = idx;
    case (state)
      READY: begin
        if (|rise) begin
          idx_next     = lowest_idx(rise);
          valid_next   = 1'b1;
          overrun_next = 1'b0;
          state_next   = PENDING;
        end else begin
          valid_next = 1'b0;
        end
      end
      PENDING: begin
        if (rd_ack) begin
          valid_next   = 1'b0;
          overrun_next = 1'b0;
          idx_next     = 2'b00;
          state_next   = (|deb_next) ? RELEASE : READY;
        end else if (|rise) begin
          overrun_next = 1'b1;
        end else begin
          valid_next = 1'b1;
        end
      end
      RELEASE: begin
        valid_next = 1'b0;
        if (~|deb) begin
          state_next = READY;
        end else begin
          state_next = RELEASE;
        end
      end
      default: begin
        state_next   = READY;
        valid_next   = 1'b0;
        overrun_next = 1'b0;
        idx_next     = 2'b00;
      end
    endcase
  end

  // FSM state and registered event fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= READY;
      valid   <= 1'b0;
      overrun <= 1'b0;
      idx     <= 2'b00;
    end else begin
      state   <= state_next;
      valid   <= valid_next;
      overrun <= overrun_next;
      idx     <= idx_next;
    end
  end

  assign data_out = {valid, overrun, 4'b0000, idx};

endmodule

// File: tb/tb_button_capture.sv
// Directed bench for button_capture with DEB_CYCLES=4: a steady press is first
// sampled at edge e0 and shows as valid just after edge e5.
module tb_button_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic       rd_ack;
  logic [7:0] data_out;
  logic       valid;

  int tests = 0;
  int fails = 0;

  button_capture #(.N_BTN(4), .DEB_CYCLES(4), .CNT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .rd_ack   (rd_ack),
    .data_out (data_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance n edges, leaving time 1ns past the last edge
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp);
    check_eq(tag, data_out, exp);
    check_eq({tag, "_valid"}, {7'b0000000, valid}, {7'b0000000, exp[7]});
  endtask

  initial begin
    reset   = 1'b1;
    btn_raw = 4'b0000;
    rd_ack  = 1'b0;
    step(2);
    reset = 1'b0;
    check_out("reset", 8'h00);

    // 1: single press of btn2, exact latency, ack, release
    btn_raw = 4'b0100;
    step(5);
    check_out("t1_before_e5", 8'h00);
    step(1);
    check_out("t1_event", 8'h82);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check_out("t1_ack", 8'h00);
    step(4);
    check_out("t1_release_held", 8'h00);
    btn_raw = 4'b0000;
    step(8);
    check_out("t1_idle", 8'h00);

    // 2: 3-cycle glitch never produces an event
    btn_raw = 4'b0001;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) btn_raw = 4'b0000;
      step(1);
      check_out("t2_glitch", 8'h00);
    end

    // 3: overrun while btn0 pending
    btn_raw = 4'b0001;
    step(6);
    check_out("t3_event", 8'h80);
    btn_raw = 4'b1001;
    step(6);
    check_out("t3_overrun", 8'hC0);
    btn_raw = 4'b0001;
    step(6);
    check_out("t3_sticky", 8'hC0);
    btn_raw = 4'b1001;
    step(6);
    check_out("t3_repress", 8'hC0);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check_out("t3_ack", 8'h00);
    btn_raw = 4'b0000;
    step(8);
    check_out("t3_idle", 8'h00);

    // 4: simultaneous rises, lowest index wins, no overrun
    btn_raw = 4'b1010;
    step(6);
    check_out("t4_event", 8'h81);
    step(3);
    check_out("t4_hold", 8'h81);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check_out("t4_ack", 8'h00);
    btn_raw = 4'b0000;
    step(8);

    // 5: ack on the same cycle as a btn2 debounced rise
    btn_raw = 4'b0001;
    step(6);
    check_out("t5_event", 8'h80);
    btn_raw = 4'b0101;
    step(5);
    check_out("t5_pre_rise", 8'h80);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    check_out("t5_ack_wins", 8'h00);
    step(6);
    check_out("t5_held", 8'h00);
    btn_raw = 4'b0100;
    step(8);
    check_out("t5_btn2_still_held", 8'h00);
    btn_raw = 4'b0000;
    step(8);
    check_out("t5_released", 8'h00);
    btn_raw = 4'b0100;
    step(6);
    check_out("t5_repress", 8'h82);
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    btn_raw = 4'b0000;
    step(8);

    // 6: reset while pending, held button must debounce again
    btn_raw = 4'b1000;
    step(6);
    check_out("t6_event", 8'h83);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_out("t6_reset", 8'h00);
    for (int k = 0; k < 5; k++) begin
      step(1);
      check_out("t6_redebounce", 8'h00);
    end
    step(1);
    check_out("t6_event_again", 8'h83);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
